// File: rtl/tkz_bank_lanes.sv
// ---------------------------------------------------------------------------
// tkz_bank_lanes
//   Tweakey-Z state bank for the Romulus SKINNY datapath. Holds LANES lanes of
//   LANE_W bits each (W = LANE_W*LANES) and reloads them from the forward or
//   reverted SKINNY tweakey. Also supports a direct parallel load, an in-place
//   block-counter LFSR step over tkz[CTR_W-1:0] and a one-deep shadow register
//   for snapshot/restore/swap.
//
//   Build option: define TKZ_LANE_SERIAL_EN for lane-serial update. In that
//   build one LANE_W-bit mux feeds the lanes, one lane per cycle, driven by a
//   lane pointer. Otherwise all lanes update in the same cycle and busy is 0.
//
// Ports
//   clk               in  1  clock, rising edge
//   rst               in  1  asynchronous reset, active low
//   load              in  1  parallel load strobe (highest priority)
//   load_data         in  W  value for load
//   upd               in  1  start a SKINNY tweakey update
//   enc               in  1  1 = skinny_tkz, 0 = skinny_tkz_revert
//   skinny_tkz        in  W  forward-round tweakey
//   skinny_tkz_revert in  W  inverse-round tweakey
//   ctr_inc           in  1  step the block-counter LFSR once
//   snap              in  1  copy tkz into the shadow register
//   restore           in  1  copy the shadow register into tkz
//   tkz               out W  current state, registered
//   busy              out 1  serial update in progress (0 in parallel build)
//   done              out 1  one-cycle pulse after an update completes
// ---------------------------------------------------------------------------
module tkz_bank_lanes #(
  parameter int                        LANE_W = 32,
  parameter int                        LANES  = 2,
  parameter logic [LANE_W*LANES-1:0]   INIT   = {32'h01000000, 32'h00000000},
  parameter int                        CTR_W  = 56
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [LANE_W*LANES-1:0]    load_data,
  input  logic                       upd,
  input  logic                       enc,
  input  logic [LANE_W*LANES-1:0]    skinny_tkz,
  input  logic [LANE_W*LANES-1:0]    skinny_tkz_revert,
  input  logic                       ctr_inc,
  input  logic                       snap,
  input  logic                       restore,
  output logic [LANE_W*LANES-1:0]    tkz,
  output logic                       busy,
  output logic                       done
);

  localparam int W = LANE_W * LANES;

  // One LFSR step on the counter field; bits above CTR_W pass through.
  // Feedback x^56+x^7+x^4+x^2+1 -> XOR 0x95 when the MSB shifts out.
  // An all-zero counter maps to itself.
  function automatic logic [W-1:0] ctr_step(input logic [W-1:0] v);
    logic [CTR_W-1:0] c;
    logic [W-1:0]     r;
    c = v[CTR_W-1:0];
    if (c[CTR_W-1]) c = (c << 1) ^ CTR_W'(8'h95);
    else            c = c << 1;
    r            = v;
    r[CTR_W-1:0] = c;
    return r;
  endfunction

  logic [W-1:0] tkz_q, tkz_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         done_q, done_d;

`ifdef TKZ_LANE_SERIAL_EN
  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic             busy_q, busy_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [LANE_W-1:0] lane_src;
  logic             lane_wr;

  // Single narrow write path: the pointed-to lane of the selected source.
  assign lane_src = enc ? skinny_tkz[int'(ptr_q)*LANE_W +: LANE_W]
                        : skinny_tkz_revert[int'(ptr_q)*LANE_W +: LANE_W];
  // A new upd is accepted only when idle; while busy the sequence continues.
  assign lane_wr  = busy_q | upd;

  always_comb begin
    tkz_d    = tkz_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    if (snap) shadow_d = tkz_q;
    if (load) begin
      tkz_d  = load_data;
      busy_d = 1'b0;
      ptr_d  = '0;
    end else if (restore) begin
      tkz_d  = shadow_q;
      busy_d = 1'b0;
      ptr_d  = '0;
    end else if (lane_wr) begin
      tkz_d[int'(ptr_q)*LANE_W +: LANE_W] = lane_src;
      if (ptr_q == PTR_W'(LANES - 1)) begin
        busy_d = 1'b0;
        ptr_d  = '0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
      end
    end else if (ctr_inc) begin
      tkz_d = ctr_step(tkz_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign busy = busy_q;
`else
  always_comb begin
    tkz_d    = tkz_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    if (snap) shadow_d = tkz_q;
    if (load) begin
      tkz_d = load_data;
    end else if (restore) begin
      tkz_d = shadow_q;
    end else if (upd) begin
      tkz_d  = enc ? skinny_tkz : skinny_tkz_revert;
      done_d = 1'b1;
    end else if (ctr_inc) begin
      tkz_d = ctr_step(tkz_q);
    end
  end

  assign busy = 1'b0;
`endif

  // State registers: everything updates on the single rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tkz_q    <= INIT;
      shadow_q <= INIT;
      done_q   <= 1'b0;
    end else begin
      tkz_q    <= tkz_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  assign tkz  = tkz_q;
  assign done = done_q;

endmodule
